add_operand_loader: RTL

- Upstream/downstream wrapper for the combinational 32-bit adder `part_4_top_module`.
- Accepts operands byte-serially over an 8-bit valid/ready stream and assembles registered 32-bit `a` and `b`, which drive the adder.
- Captures the adder's `sum` into a result register and presents it on a valid/ready output.
- Lets the lab adder sit behind a narrow host/UART-style byte interface.

---
 rtl/add_lab_pkg.sv | 24 ++
 rtl/byte_lane_reg.sv | 47 ++++
 rtl/add_operand_loader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/add_lab_pkg.sv
// ---------------------------------------------------------------------------
// add_lab_pkg
// Shared definitions for the byte-serial operand loader around the lab adder.
//   state_t     : loader FSM states (LOAD_A, LOAD_B, CAPTURE, OUT)
//   DEF_DATA_W  : default operand/result width
//   DEF_BYTE_W  : default input stream width
//   NBYTES      : bytes per operand at the default widths
//   CNT_W       : byte counter width at the default widths
// ---------------------------------------------------------------------------
package add_lab_pkg;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        CAPTURE,
        OUT
    } state_t;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_BYTE_W = 8;
    localparam int unsigned NBYTES     = DEF_DATA_W / DEF_BYTE_W;
    localparam int unsigned CNT_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1;

endpackage

// File: rtl/byte_lane_reg.sv
// ---------------------------------------------------------------------------
// byte_lane_reg
// DATA_W-bit register written one BYTE_W lane at a time; unwritten lanes hold.
//   clk, rst : clock, asynchronous active-high reset (clears to 0)
//   we       : write enable for the selected lane
//   lane     : lane index, lane k covers bits [BYTE_W*k +: BYTE_W]
//   din      : byte to write
//   q        : register contents
// ---------------------------------------------------------------------------
module byte_lane_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned LANE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [LANE_W-1:0] lane,
    input  logic [BYTE_W-1:0] din,
    output logic [DATA_W-1:0] q
);

    localparam int unsigned N_LANES = DATA_W / BYTE_W;

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            if (we && (lane == LANE_W'(i))) begin
                q_d[i*BYTE_W +: BYTE_W] = din;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/add_operand_loader.sv
// ---------------------------------------------------------------------------
// add_operand_loader
// Byte-serial front end for the combinational adder part_4_top_module.
// Operands A then B arrive LSB-first on an 8-bit valid/ready stream and are
// assembled into registered a/b feeding the adder; the adder's sum is
// captured one cycle after the last B byte and offered on res_valid/res_ready.
//   clk, rst            : clock, asynchronous active-high reset
//   in_data/in_valid    : operand byte stream (LSB first, A then B)
//   in_ready            : high in LOAD_A/LOAD_B
//   a, b                : registered operands to the adder
//   sum                 : combinational adder result
//   res_data/res_valid  : captured sum and its valid flag
//   res_ready           : consumer accepts res_data
//   busy                : state != LOAD_A or byte count != 0
//   res_carry           : unsigned carry-out, only with ADD_CARRY_OUT_EN
// Build option: define ADD_CARRY_OUT_EN to add the res_carry output.
// ---------------------------------------------------------------------------
module add_operand_loader
    import add_lab_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned BYTE_W = DEF_BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] sum,
    output logic [DATA_W-1:0] res_data,
    output logic              res_valid,
    input  logic              res_ready,
`ifdef ADD_CARRY_OUT_EN
    output logic              res_carry,
`endif
    output logic              busy
);

    localparam int unsigned N_LANES = DATA_W / BYTE_W;
    localparam int unsigned LANE_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N_LANES - 1);

    state_t            state_q, state_d;
    logic [LANE_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_valid_q, res_valid_d;
    logic              accept;
    logic              we_a, we_b;
`ifdef ADD_CARRY_OUT_EN
    logic              res_carry_q, res_carry_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
`ifdef ADD_CARRY_OUT_EN
        res_carry_d = res_carry_q;
`endif
        in_ready    = (state_q == LOAD_A) || (state_q == LOAD_B);
        accept      = in_valid && in_ready;
        we_a        = accept && (state_q == LOAD_A);
        we_b        = accept && (state_q == LOAD_B);

        case (state_q)
            LOAD_A, LOAD_B: begin
                if (accept) begin
                    if (cnt_q == LAST_LANE) begin
                        cnt_d   = '0;
                        state_d = (state_q == LOAD_A) ? LOAD_B : CAPTURE;
                    end else begin
                        cnt_d = cnt_q + LANE_W'(1);
                    end
                end
            end
            CAPTURE: begin
                res_data_d  = sum;
                res_valid_d = 1'b1;
`ifdef ADD_CARRY_OUT_EN
                // a wrapped sum is smaller than either addend exactly on carry-out
                res_carry_d = (sum < a);
`endif
                state_d     = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = LOAD_A;
                end
            end
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

`ifdef ADD_CARRY_OUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_carry_q <= 1'b0;
        end else begin
            res_carry_q <= res_carry_d;
        end
    end

    assign res_carry = res_carry_q;
`endif

    byte_lane_reg #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W),
        .LANE_W (LANE_W)
    ) u_reg_a (
        .clk  (clk),
        .rst  (rst),
        .we   (we_a),
        .lane (cnt_q),
        .din  (in_data),
        .q    (a)
    );

    byte_lane_reg #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W),
        .LANE_W (LANE_W)
    ) u_reg_b (
        .clk  (clk),
        .rst  (rst),
        .we   (we_b),
        .lane (cnt_q),
        .din  (in_data),
        .q    (b)
    );

    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != LOAD_A) || (cnt_q != '0);

endmodule
